// File: rtl/countdown_timer_mmss_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | countdown_pkg                                                    |
// | Shared states, BCD digit type and clamp helper for the mm:ss     |
// | countdown timer.                                                 |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package countdown_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOADED = 3'd1,
        RUN    = 3'd2,
        PAUSE  = 3'd3,
        DONE   = 3'd4
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t SEC_TENS_MAX = 4'd5;
    localparam bcd_digit_t DIGIT_MAX    = 4'd9;

    function automatic bcd_digit_t clamp_digit(input bcd_digit_t d, input bcd_digit_t lim);
        return (d > lim) ? lim : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/countdown_timer_mmss_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | countdown_timer_mmss_if                                          |
// | Button, load and display signals of the mm:ss countdown timer.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface countdown_timer_mmss_if #(
    parameter int MIN_DIGITS = 2
);
    logic                        load_btn;
    logic                        start_btn;
    logic [4*(MIN_DIGITS+2)-1:0] load_bcd;
    logic [4*(MIN_DIGITS+2)-1:0] digits_bcd;
    logic                        running;
    logic                        done;
    logic                        tick;

    modport master (
        output load_btn, start_btn, load_bcd,
        input  digits_bcd, running, done, tick
    );

    modport slave (
        input  load_btn, start_btn, load_bcd,
        output digits_bcd, running, done, tick
    );
endinterface
`default_nettype wire

// File: rtl/countdown_timer_mmss_btn_edge_sync.sv
`default_nettype none
// +------------------------------------------------------------------+
// | btn_edge_sync                                                    |
// | Two-flop synchroniser for an async button plus rising-edge pulse.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module btn_edge_sync (
    input  wire  clock,
    input  wire  reset,
    input  wire  btn,
    output logic pulse
);
    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign pulse = r_sync2 & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/countdown_timer_mmss.sv
`default_nettype none
// +------------------------------------------------------------------+
// | countdown_timer_mmss                                             |
// | Prescaled BCD mm:ss countdown with run/pause, done and clamping. |
// | Optional macro AUTO_RELOAD_EN: reload the captured value at 0.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module countdown_timer_mmss
    import countdown_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int TICK_HZ    = 1,
    parameter int MIN_DIGITS = 2
) (
    input wire                    clock,
    input wire                    reset,
    countdown_timer_mmss_if.slave bus
);
    localparam int c_ndig = MIN_DIGITS + 2;
    localparam int c_w    = 4 * c_ndig;
    localparam int c_div  = CLK_HZ / TICK_HZ;
    localparam int c_pw   = (c_div > 1) ? $clog2(c_div) : 1;
    localparam logic [c_pw-1:0] c_presc_last = c_pw'(c_div - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [c_w-1:0]   r_digits;
    logic [c_w-1:0]   w_digits_next;
    logic [c_pw-1:0]  r_presc;
    logic [c_pw-1:0]  w_presc_next;
    logic             r_tick;
    logic             w_tick_next;
    logic             r_done;
    logic             w_done_next;
    logic             w_load_pulse;
    logic             w_start_pulse;
    logic [c_w-1:0]   w_loaded;
    logic [c_w-1:0]   w_dec;
`ifdef AUTO_RELOAD_EN
    logic [c_w-1:0]   r_reload;
    logic [c_w-1:0]   w_reload_next;
`endif

    btn_edge_sync u_load_sync (
        .clock (clock),
        .reset (reset),
        .btn   (bus.load_btn),
        .pulse (w_load_pulse)
    );

    btn_edge_sync u_start_sync (
        .clock (clock),
        .reset (reset),
        .btn   (bus.start_btn),
        .pulse (w_start_pulse)
    );

    // Digit 1 is seconds tens (0..5); every other digit spans 0..9.
    function automatic logic [c_w-1:0] clamp_load(input logic [c_w-1:0] v);
        logic [c_w-1:0] r;
        r = '0;
        for (int i = 0; i < c_ndig; i++) begin
            r[4*i +: 4] = clamp_digit(v[4*i +: 4], (i == 1) ? SEC_TENS_MAX : DIGIT_MAX);
        end
        return r;
    endfunction

    function automatic logic [c_w-1:0] bcd_dec(input logic [c_w-1:0] v);
        logic [c_w-1:0] r;
        logic           borrow;
        r      = v;
        borrow = (v != '0);
        for (int i = 0; i < c_ndig; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = (i == 1) ? SEC_TENS_MAX : DIGIT_MAX;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign w_loaded = clamp_load(bus.load_bcd);
    assign w_dec    = bcd_dec(r_digits);

    always_comb begin
        w_state_next  = r_state;
        w_digits_next = r_digits;
        w_presc_next  = r_presc;
        w_tick_next   = 1'b0;
        w_done_next   = r_done;
`ifdef AUTO_RELOAD_EN
        w_reload_next = r_reload;
`endif
        if (w_load_pulse) begin
            // A simultaneous start edge is deliberately dropped here.
            w_state_next  = LOADED;
            w_digits_next = w_loaded;
            w_presc_next  = '0;
            w_done_next   = 1'b0;
`ifdef AUTO_RELOAD_EN
            w_reload_next = w_loaded;
`endif
        end else begin
            case (r_state)
                LOADED, PAUSE: begin
                    if (w_start_pulse) begin
                        w_presc_next = '0;
                        if (r_digits == '0) begin
                            w_state_next = DONE;
                            w_done_next  = 1'b1;
                        end else begin
                            w_state_next = RUN;
                        end
                    end
                end
                RUN: begin
                    w_done_next = 1'b0;
                    if (w_start_pulse) begin
                        w_state_next = PAUSE;
                    end else if (r_presc == c_presc_last) begin
                        w_presc_next  = '0;
                        w_tick_next   = 1'b1;
                        w_digits_next = w_dec;
                        if (w_dec == '0) begin
                            w_done_next = 1'b1;
`ifdef AUTO_RELOAD_EN
                            if (r_reload != '0) begin
                                w_digits_next = r_reload;
                            end else begin
                                w_state_next = DONE;
                            end
`else
                            w_state_next = DONE;
`endif
                        end
                    end else begin
                        w_presc_next = r_presc + c_pw'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_digits <= '0;
            r_presc  <= '0;
            r_tick   <= 1'b0;
            r_done   <= 1'b0;
`ifdef AUTO_RELOAD_EN
            r_reload <= '0;
`endif
        end else begin
            r_state  <= w_state_next;
            r_digits <= w_digits_next;
            r_presc  <= w_presc_next;
            r_tick   <= w_tick_next;
            r_done   <= w_done_next;
`ifdef AUTO_RELOAD_EN
            r_reload <= w_reload_next;
`endif
        end
    end

    assign bus.digits_bcd = r_digits;
    assign bus.running    = (r_state == RUN);
    assign bus.done       = r_done;
    assign bus.tick       = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer_mmss.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_countdown_timer_mmss                                          |
// | Seconds-count model plus directed literal checks for the timer.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_countdown_timer_mmss;
    localparam int DIV = 10;
    localparam int M_IDLE = 0, M_LOADED = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;

    logic clock = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    countdown_timer_mmss_if #(.MIN_DIGITS(2)) bus ();

    countdown_timer_mmss #(
        .CLK_HZ     (10),
        .TICK_HZ    (1),
        .MIN_DIGITS (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Model: value held as a plain number of seconds.
    int       m_state = M_IDLE;
    int       m_secs = 0;
    int       m_reload = 0;
    int       m_elapsed = 0;
    logic     m_done = 1'b0;
    logic     m_tick = 1'b0;
    logic [2:0] lph = '0;
    logic [2:0] sph = '0;

    function automatic int bcd_to_secs(input logic [15:0] v);
        int mt, mo, st, so;
        mt = (v[15:12] > 9) ? 9 : int'(v[15:12]);
        mo = (v[11:8]  > 9) ? 9 : int'(v[11:8]);
        st = (v[7:4]   > 5) ? 5 : int'(v[7:4]);
        so = (v[3:0]   > 9) ? 9 : int'(v[3:0]);
        return (mt * 10 + mo) * 60 + st * 10 + so;
    endfunction

    function automatic logic [15:0] secs_to_bcd(input int s);
        int m, r;
        m = s / 60;
        r = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
    endfunction

    initial begin
        forever begin
            logic ld, st;
            @(posedge clock or posedge reset);
            if (reset) begin
                m_state = M_IDLE; m_secs = 0; m_reload = 0; m_elapsed = 0;
                m_done = 1'b0; m_tick = 1'b0; lph = '0; sph = '0;
            end else begin
                // Button acts on the third clock edge after the pin is seen high.
                ld  = lph[1] & ~lph[2];
                st  = sph[1] & ~sph[2];
                lph = {lph[1:0], bus.load_btn};
                sph = {sph[1:0], bus.start_btn};
                m_tick = 1'b0;
                if (ld) begin
                    m_state = M_LOADED; m_secs = bcd_to_secs(bus.load_bcd);
                    m_reload = m_secs; m_elapsed = 0; m_done = 1'b0;
                end else if (m_state == M_LOADED || m_state == M_PAUSE) begin
                    if (st) begin
                        m_elapsed = 0;
                        if (m_secs == 0) begin m_state = M_DONE; m_done = 1'b1; end
                        else m_state = M_RUN;
                    end
                end else if (m_state == M_RUN) begin
                    m_done = 1'b0;
                    if (st) m_state = M_PAUSE;
                    else begin
                        m_elapsed++;
                        if (m_elapsed == DIV) begin
                            m_elapsed = 0;
                            m_tick = 1'b1;
                            m_secs--;
                            if (m_secs == 0) begin
                                m_done = 1'b1;
`ifdef AUTO_RELOAD_EN
                                if (m_reload != 0) m_secs = m_reload;
                                else m_state = M_DONE;
`else
                                m_state = M_DONE;
`endif
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            #1;
            n_vec++;
            if (bus.digits_bcd !== secs_to_bcd(m_secs) || bus.running !== (m_state == M_RUN) ||
                bus.done !== m_done || bus.tick !== m_tick) begin
                n_err++;
                $display("FAIL model t=%0t digits=%h want %h running=%b want %b done=%b want %b tick=%b want %b",
                         $time, bus.digits_bcd, secs_to_bcd(m_secs), bus.running, (m_state == M_RUN),
                         bus.done, m_done, bus.tick, m_tick);
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got %h want %h", nm, $time, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press_load();
        bus.load_btn = 1'b1;
        @(negedge clock);
        bus.load_btn = 1'b0;
    endtask

    task automatic press_start();
        bus.start_btn = 1'b1;
        @(negedge clock);
        bus.start_btn = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.load_btn  = 1'b0;
        bus.start_btn = 1'b0;
        bus.load_bcd  = 16'h0000;
        cyc(3);
        chk("rst_digits", bus.digits_bcd, 16'h0000);
        chk("rst_running", 16'(bus.running), 16'h0);
        chk("rst_done", 16'(bus.done), 16'h0);
        chk("rst_tick", 16'(bus.tick), 16'h0);
        reset = 1'b0;
        cyc(3);

        // 01:05 counts down through the minute borrow
        bus.load_bcd = 16'h0105;
        press_load(); cyc(3);
        chk("load_0105", bus.digits_bcd, 16'h0105);
        press_start(); cyc(11);
        chk("pre_tick_digits", bus.digits_bcd, 16'h0105);
        chk("pre_tick_tick", 16'(bus.tick), 16'h0);
        chk("pre_tick_running", 16'(bus.running), 16'h1);
        cyc(1);
        chk("first_tick_digits", bus.digits_bcd, 16'h0104);
        chk("first_tick_tick", 16'(bus.tick), 16'h1);
        cyc(50);
        chk("borrow_0059", bus.digits_bcd, 16'h0059);

        // 00:02 reaches zero (loaded while running)
        bus.load_bcd = 16'h0002;
        press_load(); cyc(3);
        chk("load_0002", bus.digits_bcd, 16'h0002);
        chk("load_stops_run", 16'(bus.running), 16'h0);
        press_start(); cyc(12);
        chk("tick_0001", bus.digits_bcd, 16'h0001);
        cyc(10);
        chk("zero_done", 16'(bus.done), 16'h1);
`ifdef AUTO_RELOAD_EN
        chk("reload_digits", bus.digits_bcd, 16'h0002);
        chk("reload_running", 16'(bus.running), 16'h1);
        cyc(1);
        chk("reload_done_pulse", 16'(bus.done), 16'h0);
        cyc(50);
`else
        chk("zero_digits", bus.digits_bcd, 16'h0000);
        chk("zero_running", 16'(bus.running), 16'h0);
        cyc(50);
        chk("done_held", 16'(bus.done), 16'h1);
        chk("done_digits_held", bus.digits_bcd, 16'h0000);
`endif

        // Clamp 9F:7A -> 99:59, then pause and resume
        bus.load_bcd = 16'h9F7A;
        press_load(); cyc(3);
        chk("clamp_9959", bus.digits_bcd, 16'h9959);
        press_start(); cyc(12);
        chk("tick_9958", bus.digits_bcd, 16'h9958);
        cyc(10);
        chk("tick_9957", bus.digits_bcd, 16'h9957);
        cyc(2);
        press_start(); cyc(2);
        chk("paused", 16'(bus.running), 16'h0);
        cyc(35);
        chk("pause_frozen", bus.digits_bcd, 16'h9957);
        press_start(); cyc(11);
        chk("resume_no_tick_yet", bus.digits_bcd, 16'h9957);
        cyc(1);
        chk("resume_tick", bus.digits_bcd, 16'h9956);

        // Load and start edges together: load wins
        bus.load_bcd  = 16'h0230;
        bus.load_btn  = 1'b1;
        bus.start_btn = 1'b1;
        @(negedge clock);
        bus.load_btn  = 1'b0;
        bus.start_btn = 1'b0;
        cyc(2);
        chk("both_digits", bus.digits_bcd, 16'h0230);
        chk("both_running", 16'(bus.running), 16'h0);
        cyc(5);

        // Start with 00:00 loaded goes straight to DONE; start in DONE ignored
        bus.load_bcd = 16'h0000;
        press_load(); cyc(5);
        press_start(); cyc(2);
        chk("zero_start_done", 16'(bus.done), 16'h1);
        press_start(); cyc(5);
        chk("done_ignores_start", 16'(bus.running), 16'h0);

        // Async reset mid-run with a load edge still in the synchroniser
        bus.load_bcd = 16'h0230;
        press_load(); cyc(5);
        press_start(); cyc(20);
        chk("run_before_reset", 16'(bus.running), 16'h1);
        bus.load_btn = 1'b1;
        @(negedge clock);
        bus.load_btn = 1'b0;
        reset = 1'b1;
        #3;
        chk("async_rst_digits", bus.digits_bcd, 16'h0000);
        chk("async_rst_running", 16'(bus.running), 16'h0);
        chk("async_rst_done", 16'(bus.done), 16'h0);
        cyc(3);
        reset = 1'b0;
        cyc(6);
        chk("pending_load_dropped", bus.digits_bcd, 16'h0000);
        press_start(); cyc(5);
        chk("idle_ignores_start", 16'(bus.running), 16'h0);

        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
